top_mul_pipe_rnd_sat: RTL and testbench

//  Pipelined fixed-point multiplier for the yuv2rgb datapath and later ISAX kernels.

---
 rtl/top_mul_pipe_rnd_sat_if.sv | 25 ++
 rtl/top_mul_pipe_rnd_sat.sv | 194 +++++++++++++++++++
 tb/tb_top_mul_pipe_rnd_sat.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/top_mul_pipe_rnd_sat_if.sv
// Operand/result bundle for the pipelined scaled multiplier.
// The producer drives the master side; the multiplier is the slave.
interface top_mul_pipe_rnd_sat_if #(
  parameter int din0_WIDTH = 8,
  parameter int din1_WIDTH = 9,
  parameter int dout_WIDTH = 8
);
  logic                  ce;
  logic                  in_valid;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  out_valid;
  logic [dout_WIDTH-1:0] dout;
  logic                  sat;

  modport master (
    output ce, in_valid, din0, din1,
    input  out_valid, dout, sat
  );

  modport slave (
    input  ce, in_valid, din0, din1,
    output out_valid, dout, sat
  );
endinterface

// File: rtl/top_mul_pipe_rnd_sat.sv
// Pipelined fixed-point multiplier with shift, round half-up and saturate.
// Operand regs, product reg, optional delay regs, then the output register.
module top_mul_pipe_rnd_sat #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 8,
  parameter int din1_WIDTH = 9,
  parameter int dout_WIDTH = 8,
  parameter int SHIFT      = 8,
  parameter int SIGNED0    = 1,
  parameter int SIGNED1    = 1,
  parameter int ROUND      = 1,
  parameter int SAT        = 1
) (
  input logic clk,
  input logic reset,
  top_mul_pipe_rnd_sat_if.slave bus
);
  localparam int P = din0_WIDTH + din1_WIDTH + 1;
  localparam int W = dout_WIDTH;
  localparam int E = P - W + 2;
  localparam bit RS = (SIGNED0 != 0) || (SIGNED1 != 0);
  localparam logic [P:0] RND =
    (ROUND != 0) ? (P+1)'((2 ** SHIFT) / 2) : '0;

  if (NUM_STAGE < 1 || NUM_STAGE > 6 || SHIFT < 0 ||
      SHIFT >= P || W > P || ID < 0) begin : g_bad_cfg
    $error("top_mul_pipe_rnd_sat: illegal parameters");
  end

  function automatic logic [P-1:0] mul_f(
    input logic [din0_WIDTH-1:0] a,
    input logic [din1_WIDTH-1:0] b
  );
    logic [P-1:0] ax;
    logic [P-1:0] bx;
    ax = {{(P-din0_WIDTH){(SIGNED0 != 0) & a[din0_WIDTH-1]}}, a};
    bx = {{(P-din1_WIDTH){(SIGNED1 != 0) & b[din1_WIDTH-1]}}, b};
    return ax * bx;
  endfunction

  // Returns {sat, dout}; rounding is done one bit wider than the product.
  function automatic logic [W:0] scale_f(input logic [P-1:0] p);
    logic [P:0] x;
    logic [P:0] q;
    logic [W:0] r;
    x = {RS & p[P-1], p} + RND;
    if (RS) q = $unsigned($signed(x) >>> SHIFT);
    else    q = x >> SHIFT;
    r = {1'b0, q[W-1:0]};
    if (SAT != 0) begin
      if (RS && (q[P:W-1] != {E{q[P]}}))
        r = {1'b1, q[P], {(W-1){~q[P]}}};
      else if (!RS && (q[P:W] != '0))
        r = {1'b1, {W{1'b1}}};
    end
    return r;
  endfunction

  logic         ov_q, ov_d;
  logic         sat_q, sat_d;
  logic [W-1:0] dout_q, dout_d;
  logic         last_v;
  logic [W:0]   last_r;

  if (NUM_STAGE == 1) begin : g_one
    always_comb begin
      last_v = bus.in_valid;
      last_r = scale_f(mul_f(bus.din0, bus.din1));
    end
  end else begin : g_multi
    logic [din0_WIDTH-1:0] a_q, a_d;
    logic [din1_WIDTH-1:0] b_q, b_d;
    logic                  v1_q, v1_d;

    always_comb begin
      a_d  = a_q;
      b_d  = b_q;
      v1_d = v1_q;
      if (bus.ce) begin
        a_d  = bus.din0;
        b_d  = bus.din1;
        v1_d = bus.in_valid;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        a_q  <= '0;
        b_q  <= '0;
        v1_q <= 1'b0;
      end else begin
        a_q  <= a_d;
        b_q  <= b_d;
        v1_q <= v1_d;
      end
    end

    if (NUM_STAGE == 2) begin : g_two
      always_comb begin
        last_v = v1_q;
        last_r = scale_f(mul_f(a_q, b_q));
      end
    end else begin : g_deep
      logic [P-1:0] prod_q, prod_d;
      logic         v2_q, v2_d;

      always_comb begin
        prod_d = prod_q;
        v2_d   = v2_q;
        if (bus.ce) begin
          prod_d = mul_f(a_q, b_q);
          v2_d   = v1_q;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          prod_q <= '0;
          v2_q   <= 1'b0;
        end else begin
          prod_q <= prod_d;
          v2_q   <= v2_d;
        end
      end

      if (NUM_STAGE == 3) begin : g_nodly
        always_comb begin
          last_v = v2_q;
          last_r = scale_f(prod_q);
        end
      end else begin : g_dly
        localparam int D = NUM_STAGE - 3;
        logic [D-1:0]      dv_q, dv_d;
        logic [D-1:0][W:0] dr_q, dr_d;

        always_comb begin
          dv_d = dv_q;
          dr_d = dr_q;
          if (bus.ce) begin
            dv_d[0] = v2_q;
            dr_d[0] = scale_f(prod_q);
            for (int i = 1; i < D; i++) begin
              dv_d[i] = dv_q[i-1];
              dr_d[i] = dr_q[i-1];
            end
          end
        end

        always_ff @(posedge clk) begin
          if (reset) begin
            dv_q <= '0;
            dr_q <= '0;
          end else begin
            dv_q <= dv_d;
            dr_q <= dr_d;
          end
        end

        always_comb begin
          last_v = dv_q[D-1];
          last_r = dr_q[D-1];
        end
      end
    end
  end

  // Result only reloads on a valid sample, so bubbles keep the last result.
  always_comb begin
    ov_d   = ov_q;
    sat_d  = sat_q;
    dout_d = dout_q;
    if (bus.ce) begin
      ov_d = last_v;
      if (last_v) {sat_d, dout_d} = last_r;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ov_q   <= 1'b0;
      sat_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      ov_q   <= ov_d;
      sat_q  <= sat_d;
      dout_q <= dout_d;
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.dout      = dout_q;
  assign bus.sat       = sat_q;
endmodule

// File: tb/tb_top_mul_pipe_rnd_sat.sv
// Bench for top_mul_pipe_rnd_sat: four configurations share one stimulus
// stream and are checked against an integer reference model.
module tb_top_mul_pipe_rnd_sat;
  logic       clk = 1'b0;
  logic       reset, ce, in_valid;
  logic [7:0] din0;
  logic [8:0] din1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  top_mul_pipe_rnd_sat_if #(.din0_WIDTH(8), .din1_WIDTH(9), .dout_WIDTH(8)) ifa ();
  top_mul_pipe_rnd_sat_if #(.din0_WIDTH(8), .din1_WIDTH(9), .dout_WIDTH(8)) ifb ();
  top_mul_pipe_rnd_sat_if #(.din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(8)) ifc ();
  top_mul_pipe_rnd_sat_if #(.din0_WIDTH(8), .din1_WIDTH(9), .dout_WIDTH(8)) ifd ();

  assign ifa.ce = ce; assign ifa.in_valid = in_valid;
  assign ifa.din0 = din0; assign ifa.din1 = din1;
  assign ifb.ce = ce; assign ifb.in_valid = in_valid;
  assign ifb.din0 = din0; assign ifb.din1 = din1;
  assign ifc.ce = ce; assign ifc.in_valid = in_valid;
  assign ifc.din0 = din0; assign ifc.din1 = din1[7:0];
  assign ifd.ce = ce; assign ifd.in_valid = in_valid;
  assign ifd.din0 = din0; assign ifd.din1 = din1;

  top_mul_pipe_rnd_sat #(.NUM_STAGE(3)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa));
  top_mul_pipe_rnd_sat #(.NUM_STAGE(1), .SAT(0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb));
  top_mul_pipe_rnd_sat #(.NUM_STAGE(3), .din1_WIDTH(8), .SHIFT(4),
    .SIGNED0(0), .SIGNED1(0)) dut_c (
    .clk(clk), .reset(reset), .bus(ifc));
  top_mul_pipe_rnd_sat #(.NUM_STAGE(6), .SIGNED0(0), .ROUND(0)) dut_d (
    .clk(clk), .reset(reset), .bus(ifd));

  int ns_c[4] = '{3, 1, 3, 6};
  int s0_c[4] = '{1, 1, 0, 0};
  int s1_c[4] = '{1, 1, 0, 1};
  int w1_c[4] = '{9, 9, 8, 9};
  int sh_c[4] = '{8, 8, 4, 8};
  int rn_c[4] = '{1, 1, 1, 0};
  int st_c[4] = '{1, 0, 1, 1};

  logic [7:0] sa [4096];
  logic [8:0] sb [4096];
  int         se [4096];
  int         n_smp = 0;
  int         ce_cnt = 0;
  int         rp [4] = '{0, 0, 0, 0};
  logic       exp_ov [4];
  logic [7:0] exp_d [4];
  logic       exp_s [4];
  int         got_a [$];

  function automatic void ref_f(input int d, input logic [7:0] a,
                                input logic [8:0] b,
                                output logic [7:0] r, output logic s);
    longint av, bv, p, dv, q, lo, hi;
    av = longint'(a);
    if (s0_c[d] != 0 && av >= 128) av -= 256;
    bv = (w1_c[d] == 8) ? longint'(b[7:0]) : longint'(b);
    if (s1_c[d] != 0 && bv >= (longint'(1) << (w1_c[d] - 1)))
      bv -= longint'(1) << w1_c[d];
    p = av * bv;
    if (rn_c[d] != 0 && sh_c[d] > 0) p += longint'(1) << (sh_c[d] - 1);
    dv = longint'(1) << sh_c[d];
    q = p / dv;
    if (p % dv != 0 && p < 0) q -= 1;
    if (s0_c[d] != 0 || s1_c[d] != 0) begin
      lo = -128; hi = 127;
    end else begin
      lo = 0; hi = 255;
    end
    s = 1'b0;
    if (st_c[d] != 0 && q > hi) begin
      q = hi; s = 1'b1;
    end else if (st_c[d] != 0 && q < lo) begin
      q = lo; s = 1'b1;
    end
    r = q[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_dut(input int d, input logic ov,
                         input logic [7:0] dv, input logic s);
    chk($sformatf("dut%0d_out_valid", d), 32'(ov), 32'(exp_ov[d]));
    chk($sformatf("dut%0d_dout", d), 32'(dv), 32'(exp_d[d]));
    chk($sformatf("dut%0d_sat", d), 32'(s), 32'(exp_s[d]));
  endtask

  task automatic step(input logic rs, input logic c, input logic v,
                      input logic [7:0] a, input logic [8:0] b);
    reset = rs; ce = c; in_valid = v; din0 = a; din1 = b;
    @(posedge clk);
    if (rs) begin
      for (int d = 0; d < 4; d++) begin
        exp_ov[d] = 1'b0; exp_d[d] = '0; exp_s[d] = 1'b0;
        rp[d] = n_smp;
      end
    end else if (c) begin
      ce_cnt++;
      if (v) begin
        sa[n_smp] = a; sb[n_smp] = b; se[n_smp] = ce_cnt;
        n_smp++;
      end
      for (int d = 0; d < 4; d++) begin
        exp_ov[d] = (rp[d] < n_smp) &&
                    (se[rp[d]] + ns_c[d] - 1 == ce_cnt);
        if (exp_ov[d]) begin
          ref_f(d, sa[rp[d]], sb[rp[d]], exp_d[d], exp_s[d]);
          rp[d]++;
        end
      end
    end
    #1;
    chk_dut(0, ifa.out_valid, ifa.dout, ifa.sat);
    chk_dut(1, ifb.out_valid, ifb.dout, ifb.sat);
    chk_dut(2, ifc.out_valid, ifc.dout, ifc.sat);
    chk_dut(3, ifd.out_valid, ifd.dout, ifd.sat);
    if (c && !rs && ifa.out_valid === 1'b1)
      got_a.push_back(int'(ifa.dout));
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; in_valid = 1'b0; din0 = '0; din1 = '0;
    // Reset with ce low still clears everything.
    step(1, 0, 0, 8'd0, 9'd0);
    step(1, 0, 1, 8'd5, 9'd5);
    chk("reset_out_valid", 32'(ifa.out_valid), 32'd0);
    chk("reset_dout", 32'(ifa.dout), 32'd0);
    chk("reset_sat", 32'(ifa.sat), 32'd0);

    // Rounding, saturation and wrap.
    step(0, 1, 1, 8'd100, 9'd128);
    step(0, 1, 1, 8'd3, 9'd43);
    chk("lat_not_yet", 32'(ifa.out_valid), 32'd0);
    step(0, 1, 1, 8'hFF, 9'd128);
    chk("rnd_valid", 32'(ifa.out_valid), 32'd1);
    chk("rnd_100x128", 32'(ifa.dout), 32'd50);
    chk("rnd_sat0", 32'(ifa.sat), 32'd0);
    step(0, 1, 1, 8'h80, 9'h100);
    chk("rnd_3x43", 32'(ifa.dout), 32'd1);
    chk("wrap_valid", 32'(ifb.out_valid), 32'd1);
    chk("wrap_dout", 32'(ifb.dout), 32'h80);
    chk("wrap_sat", 32'(ifb.sat), 32'd0);
    step(0, 1, 1, 8'd2, 9'd128);
    chk("rnd_tie", 32'(ifa.dout), 32'd0);
    step(0, 1, 0, 8'd0, 9'd0);
    chk("sat_dout", 32'(ifa.dout), 32'd127);
    chk("sat_flag", 32'(ifa.sat), 32'd1);
    step(0, 1, 0, 8'd0, 9'd0);
    chk("after_sat_dout", 32'(ifa.dout), 32'd1);
    chk("after_sat_flag", 32'(ifa.sat), 32'd0);
    step(0, 1, 0, 8'd0, 9'd0);
    chk("hold_valid", 32'(ifa.out_valid), 32'd0);
    chk("hold_dout", 32'(ifa.dout), 32'd1);

    // Unsigned clamp.
    step(0, 1, 1, 8'd255, 9'd255);
    step(0, 1, 0, 8'd0, 9'd0);
    step(0, 1, 0, 8'd0, 9'd0);
    chk("uns_dout", 32'(ifc.dout), 32'd255);
    chk("uns_sat", 32'(ifc.sat), 32'd1);
    repeat (4) step(0, 1, 0, 8'd0, 9'd0);

    // Stall for two cycles after B.
    got_a.delete();
    step(0, 1, 1, 8'hF6, 9'h100);
    step(0, 1, 1, 8'hEC, 9'h100);
    step(0, 0, 1, 8'h11, 9'h022);
    step(0, 0, 0, 8'h33, 9'h044);
    step(0, 1, 1, 8'hE2, 9'h100);
    repeat (6) step(0, 1, 0, 8'd0, 9'd0);
    chk("stall_count", 32'(got_a.size()), 32'd3);
    chk("stall_first", 32'(got_a.size() > 0 ? got_a[0] : -1), 32'd10);
    chk("stall_second", 32'(got_a.size() > 1 ? got_a[1] : -1), 32'd20);
    chk("stall_third", 32'(got_a.size() > 2 ? got_a[2] : -1), 32'd30);

    // Reset with two samples in flight.
    step(0, 1, 1, 8'd100, 9'd128);
    step(0, 1, 1, 8'd3, 9'd43);
    step(1, 1, 1, 8'd7, 9'd7);
    chk("rst_flight_valid", 32'(ifa.out_valid), 32'd0);
    chk("rst_flight_dout", 32'(ifa.dout), 32'd0);
    chk("rst_flight_sat", 32'(ifa.sat), 32'd0);
    repeat (7) step(0, 1, 0, 8'd0, 9'd0);
    chk("rst_flight_gone", 32'(ifd.out_valid), 32'd0);

    // Random sweep.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(9) != 0),
           ($urandom_range(3) != 0), 8'($urandom), 9'($urandom));
    end
    repeat (8) step(0, 1, 0, 8'd0, 9'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
